pipeline_scoreboard: RTL and testbench
======================================

Name: pipeline_scoreboard

Overview:
- Parametrised hazard and stall controller for the pipelined RISC-V core.
- Replaces fixed load-use detection with a per-register scoreboard that tracks the cycles remaining until each in-flight destination is usable.
- Supports variable-latency producers: ALU, load, and multi-cycle mul/div.
- Sits beside the ID stage: consumes the decoded rs1/rs2/rd plus a producer latency, and drives the PC write, IF/ID write, and ID/EX bubble controls.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is hard-wired zero and never tracked.
- IDX_W, 5, register index width; NREGS <= 2**IDX_W.
- LAT_W, 3, width of the latency field and of each counter; maximum latency is 2**LAT_W-1.
- FWD_EN, 1, 1 = a source is ready when cnt<=1 (bypass covers the last cycle); 0 = a source is ready only when cnt==0.
- STAT_W, 16, width of the stall statistics counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  IDX_W  source 1 index.
- id_rs2  in  IDX_W  source 2 index.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_wr  in  1  instruction writes rd.
- id_rd  in  IDX_W  destination index.
- id_lat  in  LAT_W  cycles from issue until the result is forwardable; 0 = no tracking.
- flush  in  1  branch/jump flush of ID this cycle.
- stall  out  1  hold ID; comb.
- pc_write  out  1  = !stall.
- if_id_write  out  1  = !stall.
- ctrl_reset  out  1  insert bubble into ID/EX; = stall | flush.
- issue  out  1  = id_valid & !stall & !flush.
- busy  out  NREGS  bit i = (cnt[i]!=0); bit 0 always 0.
- stall_cycles  out  STAT_W  saturating count of stalled cycles.

Behaviour:
- Reset: all cnt[i]=0 and stall_cycles=0. Outputs then read: stall=0, pc_write=1, if_id_write=1, busy=0, ctrl_reset=flush, issue=id_valid&!flush. Reset asserted mid-operation aborts all tracking immediately.
- Source hazard: srcN_hz = id_useN & (rsN!=0) & (FWD_EN ? cnt[rsN]>1 : cnt[rsN]!=0).
- WAW hazard: waw = id_wr & (rd!=0) & (cnt[rd] > id_lat). This prevents an older, slower write landing after a newer one.
- stall = id_valid & (src1_hz | src2_hz | waw). All checks are combinational on the registered counters; zero-cycle decision latency.
- Counter update, every posedge, for each i!=0:
  - if issue & id_wr & rd==i & id_lat!=0, then cnt[i] <= id_lat (new issue beats decrement in the same cycle);
  - else if cnt[i]!=0, cnt[i] <= cnt[i]-1;
  - else hold.
- id_wr with rd==0 or id_lat==0: nothing recorded.
- flush: suppresses issue, so the counter is not loaded. Flush does not clear existing counters, since older instructions still retire. The stall output is still computed.
- flush and stall in the same cycle: ctrl_reset=1; pc_write follows stall.
- Self-dependency (rs==rd): the check uses the pre-issue count, so the instruction is not blocked by itself.
- stall_cycles: increments when stall=1 and flush=0; saturates at all-ones (no wrap).
- No FSM beyond the counters. The block is a pure countdown scoreboard with NREGS-1 independent down-counters.

Test Plan:
1. Reset then idle, id_valid=0. Required: stall=0, busy=0, stall_cycles=0; reset asserted mid-count clears busy at once, without waiting for a clock.
2. Load x5 with lat=2, then next cycle `add x6,x5,x1` (use_rs1, FWD_EN=1). Required: cycle 1 cnt[5]=1 -> no stall; with FWD_EN=0, one stall cycle, then issue.
3. Mul x7 with lat=5, then a consumer of x7. Required: 3 stall cycles with FWD_EN=1 (cnt 4,3,2); issue on cnt=1; stall_cycles=3.
4. Mul x8 lat=5, then the next cycle `addi x8` lat=1. Required: WAW stall while cnt[8]>1; issue exactly when cnt[8]<=1; cnt[8] then loads 1.
5. Consumer of x3 with cnt[3]=3 and flush=1. Required: ctrl_reset=1, issue=0, stall_cycles unchanged; cnt[3] keeps decrementing.
6. Write to x0 with lat=7 followed by a read of x0. Required: busy[0]=0, no stall. Force STAT_W=2 with 5 stalled cycles. Required: stall_cycles=3 (saturated).

Source files
------------

// File: rtl/pipeline_scoreboard_if.sv
// ID-stage hazard bus between the decode logic and the scoreboard.
// The master side is the decoder (drives the decoded instruction fields),
// the slave side is the scoreboard (returns stall/bubble controls and status).
interface pipeline_scoreboard_if #(
  parameter int NREGS  = 32,
  parameter int IDX_W  = 5,
  parameter int LAT_W  = 3,
  parameter int STAT_W = 16
);
  logic              id_valid;
  logic [IDX_W-1:0]  id_rs1;
  logic [IDX_W-1:0]  id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_wr;
  logic [IDX_W-1:0]  id_rd;
  logic [LAT_W-1:0]  id_lat;
  logic              flush;
  logic              stall;
  logic              pc_write;
  logic              if_id_write;
  logic              ctrl_reset;
  logic              issue;
  logic [NREGS-1:0]  busy;
  logic [STAT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_wr, id_rd, id_lat, flush,
    input  stall, pc_write, if_id_write, ctrl_reset, issue, busy, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_wr, id_rd, id_lat, flush,
    output stall, pc_write, if_id_write, ctrl_reset, issue, busy, stall_cycles
  );
endinterface

// File: rtl/pipeline_scoreboard.sv
// Per-register countdown scoreboard for the ID stage. Each architectural
// register (except x0) has a down-counter holding the cycles left until its
// in-flight result can be consumed. Source (RAW) and WAW hazards are decided
// combinationally from the registered counters, giving zero-cycle stall
// decisions; issued writes reload their destination counter.
module pipeline_scoreboard #(
  parameter int NREGS  = 32,
  parameter int IDX_W  = 5,
  parameter int LAT_W  = 3,
  parameter bit FWD_EN = 1'b1,
  parameter int STAT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  pipeline_scoreboard_if.slave  sb
);

  localparam logic [LAT_W-1:0]  CNT_ONE  = LAT_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [LAT_W-1:0]  cnt_q [NREGS];
  logic [LAT_W-1:0]  cnt_d [NREGS];
  logic [STAT_W-1:0] stall_cycles_q;
  logic [STAT_W-1:0] stall_cycles_d;

  logic src1_hz;
  logic src2_hz;
  logic waw_hz;
  logic stall_c;
  logic issue_c;

  // Counter lookup; indices outside the register file read as idle.
  function automatic logic [LAT_W-1:0] cnt_at(input logic [IDX_W-1:0] idx);
    logic [LAT_W-1:0] c;
    c = '0;
    for (int k = 1; k < NREGS; k++) begin
      if (idx == IDX_W'(k)) c = cnt_q[k];
    end
    return c;
  endfunction

  // With bypassing, the final cycle of a producer is covered by forwarding.
  function automatic logic src_blocked(input logic [LAT_W-1:0] c);
    if (FWD_EN) return (c > CNT_ONE);
    else        return (c != '0);
  endfunction

  // Saturating increment for the stall statistic.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    if (v == STAT_MAX) return v;
    else               return v + STAT_W'(1);
  endfunction

  // Hazard detection against the pre-issue counters (self-dependency safe).
  always_comb begin
    src1_hz = sb.id_use_rs1 && (sb.id_rs1 != '0) && src_blocked(cnt_at(sb.id_rs1));
    src2_hz = sb.id_use_rs2 && (sb.id_rs2 != '0) && src_blocked(cnt_at(sb.id_rs2));
    waw_hz  = sb.id_wr && (sb.id_rd != '0) && (cnt_at(sb.id_rd) > sb.id_lat);
    stall_c = sb.id_valid && (src1_hz || src2_hz || waw_hz);
    issue_c = sb.id_valid && !stall_c && !sb.flush;
  end

  assign sb.stall        = stall_c;
  assign sb.pc_write     = !stall_c;
  assign sb.if_id_write  = !stall_c;
  assign sb.ctrl_reset   = stall_c || sb.flush;
  assign sb.issue        = issue_c;
  assign sb.stall_cycles = stall_cycles_q;

  // Busy vector mirrors non-zero counters; x0 is never busy.
  always_comb begin
    sb.busy    = '0;
    for (int i = 1; i < NREGS; i++) begin
      sb.busy[i] = (cnt_q[i] != '0);
    end
  end

  // Next counter values: a new issue overrides the decrement of the same cycle.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i == 0) begin
        cnt_d[i] = '0;
      end else if (issue_c && sb.id_wr && (sb.id_rd == IDX_W'(i)) && (sb.id_lat != '0)) begin
        cnt_d[i] = sb.id_lat;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
    stall_cycles_d = (stall_c && !sb.flush) ? sat_inc(stall_cycles_q) : stall_cycles_q;
  end

  // State registers; reset aborts all tracking immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard. Three instances share one stimulus:
// A = defaults (FWD_EN=1), B = FWD_EN=0, C = STAT_W=2 for saturation.
module tb_pipeline_scoreboard;

  logic clock;
  logic reset;

  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       id_wr;
  logic [4:0] id_rd;
  logic [2:0] id_lat;
  logic       flush;

  int n_cmp;
  int n_err;

  pipeline_scoreboard_if #(.NREGS(32), .IDX_W(5), .LAT_W(3), .STAT_W(16)) if_a ();
  pipeline_scoreboard_if #(.NREGS(32), .IDX_W(5), .LAT_W(3), .STAT_W(16)) if_b ();
  pipeline_scoreboard_if #(.NREGS(32), .IDX_W(5), .LAT_W(3), .STAT_W(2))  if_c ();

  pipeline_scoreboard #(.NREGS(32), .IDX_W(5), .LAT_W(3), .FWD_EN(1'b1), .STAT_W(16)) dut_a (
    .clock(clock), .reset(reset), .sb(if_a));
  pipeline_scoreboard #(.NREGS(32), .IDX_W(5), .LAT_W(3), .FWD_EN(1'b0), .STAT_W(16)) dut_b (
    .clock(clock), .reset(reset), .sb(if_b));
  pipeline_scoreboard #(.NREGS(32), .IDX_W(5), .LAT_W(3), .FWD_EN(1'b1), .STAT_W(2)) dut_c (
    .clock(clock), .reset(reset), .sb(if_c));

  // Fan the shared stimulus out to all three instances.
  always_comb begin
    if_a.id_valid = id_valid;   if_b.id_valid = id_valid;   if_c.id_valid = id_valid;
    if_a.id_rs1 = id_rs1;       if_b.id_rs1 = id_rs1;       if_c.id_rs1 = id_rs1;
    if_a.id_rs2 = id_rs2;       if_b.id_rs2 = id_rs2;       if_c.id_rs2 = id_rs2;
    if_a.id_use_rs1 = id_use_rs1; if_b.id_use_rs1 = id_use_rs1; if_c.id_use_rs1 = id_use_rs1;
    if_a.id_use_rs2 = id_use_rs2; if_b.id_use_rs2 = id_use_rs2; if_c.id_use_rs2 = id_use_rs2;
    if_a.id_wr = id_wr;         if_b.id_wr = id_wr;         if_c.id_wr = id_wr;
    if_a.id_rd = id_rd;         if_b.id_rd = id_rd;         if_c.id_rd = id_rd;
    if_a.id_lat = id_lat;       if_b.id_lat = id_lat;       if_c.id_lat = id_lat;
    if_a.flush = flush;         if_b.flush = flush;         if_c.flush = flush;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic w,
                       input logic [4:0] rd, input logic [2:0] lat, input logic fl);
    id_valid = v;  id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_wr = w;     id_rd = rd;  id_lat = lat;    flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
  endtask

  task automatic reset_pulse();
    idle();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    idle();
    cyc();
    reset = 1'b0;
    #1;

    // 1. Reset state and idle behaviour
    chk("rst_stall", 32'(if_a.stall), 32'd0);
    chk("rst_pc_write", 32'(if_a.pc_write), 32'd1);
    chk("rst_if_id_write", 32'(if_a.if_id_write), 32'd1);
    chk("rst_busy", if_a.busy, 32'd0);
    chk("rst_stall_cycles", 32'(if_a.stall_cycles), 32'd0);
    chk("rst_ctrl_reset", 32'(if_a.ctrl_reset), 32'd0);
    chk("rst_issue", 32'(if_a.issue), 32'd0);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b1);
    #1;
    chk("idle_flush_ctrl_reset", 32'(if_a.ctrl_reset), 32'd1);
    // mid-count asynchronous reset
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 3'd7, 1'b0);
    #1;
    chk("x4_issue", 32'(if_a.issue), 32'd1);
    cyc();
    idle();
    #1;
    chk("x4_busy", if_a.busy, 32'h0000_0010);
    reset = 1'b1;
    #1;
    chk("async_rst_busy", if_a.busy, 32'd0);
    cyc();
    reset = 1'b0;
    #1;

    // 2. Load x5 lat=2, one gap cycle, then add x6,x5,x1
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 3'd2, 1'b0);
    #1;
    chk("ld5_issue", 32'(if_a.issue), 32'd1);
    cyc();
    idle();
    #1;
    chk("ld5_busy", if_a.busy, 32'h0000_0020);
    cyc();
    drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 5'd6, 3'd1, 1'b0);
    #1;
    chk("add_fwd_stall", 32'(if_a.stall), 32'd0);
    chk("add_fwd_issue", 32'(if_a.issue), 32'd1);
    chk("add_nofwd_stall", 32'(if_b.stall), 32'd1);
    chk("add_nofwd_issue", 32'(if_b.issue), 32'd0);
    cyc();
    chk("add_nofwd_stall2", 32'(if_b.stall), 32'd0);
    chk("add_nofwd_issue2", 32'(if_b.issue), 32'd1);
    chk("add_nofwd_stat", 32'(if_b.stall_cycles), 32'd1);
    chk("add_fwd_stat", 32'(if_a.stall_cycles), 32'd0);
    cyc();
    reset_pulse();

    // 3. Mul x7 lat=5, gap, consumer stalls at cnt 4,3,2
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 3'd5, 1'b0);
    #1;
    cyc();
    idle();
    cyc();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mul7_stall_%0d", k), 32'(if_a.stall), 32'd1);
      chk($sformatf("mul7_pcw_%0d", k), 32'(if_a.pc_write), 32'd0);
      cyc();
    end
    chk("mul7_release_stall", 32'(if_a.stall), 32'd0);
    chk("mul7_release_issue", 32'(if_a.issue), 32'd1);
    chk("mul7_stat", 32'(if_a.stall_cycles), 32'd3);
    cyc();
    idle();
    #1;
    chk("mul7_busy_clear", if_a.busy, 32'd0);
    chk("mul7_stat_c", 32'(if_c.stall_cycles), 32'd3);
    reset_pulse();

    // 4. WAW: mul x8 lat=5 then addi x8 lat=1
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 3'd5, 1'b0);
    #1;
    cyc();
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 3'd1, 1'b0);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("waw_stall_%0d", k), 32'(if_a.stall), 32'd1);
      chk($sformatf("waw_ctrl_reset_%0d", k), 32'(if_a.ctrl_reset), 32'd1);
      cyc();
    end
    chk("waw_release_stall", 32'(if_a.stall), 32'd0);
    chk("waw_release_issue", 32'(if_a.issue), 32'd1);
    cyc();
    idle();
    #1;
    chk("waw_reload_busy", if_a.busy, 32'h0000_0100);
    cyc();
    chk("waw_done_busy", if_a.busy, 32'd0);
    chk("waw_stat", 32'(if_a.stall_cycles), 32'd4);
    reset_pulse();

    // 5. Flush while a hazard is present
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 3'd3, 1'b0);
    #1;
    cyc();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 3'd2, 1'b1);
    #1;
    chk("flush_stall", 32'(if_a.stall), 32'd1);
    chk("flush_ctrl_reset", 32'(if_a.ctrl_reset), 32'd1);
    chk("flush_issue", 32'(if_a.issue), 32'd0);
    chk("flush_pc_write", 32'(if_a.pc_write), 32'd0);
    cyc();
    chk("flush_stat", 32'(if_a.stall_cycles), 32'd0);
    chk("flush_busy_cnt2", if_a.busy, 32'h0000_0008);
    idle();
    cyc();
    chk("flush_busy_cnt1", if_a.busy, 32'h0000_0008);
    cyc();
    chk("flush_busy_cnt0", if_a.busy, 32'd0);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b1);
    #1;
    chk("flush_only_ctrl_reset", 32'(if_a.ctrl_reset), 32'd1);
    chk("flush_only_pc_write", 32'(if_a.pc_write), 32'd1);
    chk("flush_only_issue", 32'(if_a.issue), 32'd0);
    idle();
    reset_pulse();

    // 6. x0 is never tracked; stall counter saturation
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 3'd7, 1'b0);
    #1;
    chk("x0_wr_issue", 32'(if_a.issue), 32'd1);
    cyc();
    idle();
    #1;
    chk("x0_busy", if_a.busy, 32'd0);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0);
    #1;
    chk("x0_read_stall", 32'(if_a.stall), 32'd0);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 3'd7, 1'b0);
    #1;
    cyc();
    drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("sat_stall_%0d", k), 32'(if_a.stall), 32'd1);
      cyc();
    end
    idle();
    #1;
    chk("sat_stat_a", 32'(if_a.stall_cycles), 32'd5);
    chk("sat_stat_b", 32'(if_b.stall_cycles), 32'd5);
    chk("sat_stat_c", 32'(if_c.stall_cycles), 32'd3);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
